// File: rtl/adc_serial_cfg_ctrl.sv
// adc_serial_cfg_ctrl: ADC reset pulse, init word sequencer and host register port over the 3-wire SCLK/SEN/SDATA/SDOUT bus
module adc_serial_cfg_ctrl #(
  parameter int          CLK_DIV    = 5,
  parameter int          RST_CYCLES = 10,
  parameter int          RST_WAIT   = 100,
  parameter int          GAP_CYCLES = 20,
  parameter int          INIT_COUNT = 4,
  parameter logic [23:0] INIT_W0    = 24'h000001,
  parameter logic [23:0] INIT_W1    = 24'h000004,
  parameter logic [23:0] INIT_W2    = 24'h990008,
  parameter logic [23:0] INIT_W3    = 24'h9A000C
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        init_start,
  input  logic        cmd_valid,
  input  logic        cmd_read,
  input  logic [23:0] cmd_data,
  output logic        cmd_ready,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        init_done,
  output logic        adc_reset,
  output logic        adc_sclk,
  output logic        adc_sen,
  output logic        adc_sdata,
  input  logic        adc_sdout
);
  localparam int M1 = RST_WAIT > GAP_CYCLES ? RST_WAIT : GAP_CYCLES;
  localparam int M2 = M1 > CLK_DIV ? M1 : CLK_DIV;
  localparam int MX = M2 > RST_CYCLES ? M2 : RST_CYCLES;
  localparam int CW = $clog2(MX + 1);
  localparam logic [CW-1:0] DIV_LD = CW'(CLK_DIV - 1);
  localparam logic [1:0] LAST = 2'(INIT_COUNT - 1);
  typedef enum logic [2:0] {S_IDLE, S_RST_PULSE, S_RST_WAIT, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [4:0] bit_cnt, bit_cnt_n;
  logic ph, ph_n, is_rd, is_rd_n, init_mode, init_mode_n;
  logic [1:0] widx, widx_n, wsel;
  logic [23:0] sh, sh_n, iw;
  logic [15:0] rd_sh, rd_sh_n, rd_data_n;
  logic rd_valid_n, init_done_n, adc_reset_n, adc_sclk_n, adc_sen_n, adc_sdata_n;
  assign busy = state != S_IDLE;
  assign cmd_ready = state == S_IDLE && init_done;
  assign wsel = state == S_GAP ? widx + 2'd1 : 2'd0;
  assign iw = wsel == 2'd0 ? INIT_W0 : wsel == 2'd1 ? INIT_W1 : wsel == 2'd2 ? INIT_W2 : INIT_W3;
  // Pin values are computed for the next state and registered, so the pins never glitch.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_cnt_n   = bit_cnt;
    ph_n        = ph;
    is_rd_n     = is_rd;
    init_mode_n = init_mode;
    widx_n      = widx;
    sh_n        = sh;
    rd_sh_n     = rd_sh;
    rd_data_n   = rd_data;
    rd_valid_n  = 1'b0;
    init_done_n = init_done;
    adc_reset_n = adc_reset;
    adc_sclk_n  = adc_sclk;
    adc_sen_n   = adc_sen;
    adc_sdata_n = adc_sdata;
    if (state == S_SHIFT && ph && cnt == DIV_LD && bit_cnt < 5'd16) rd_sh_n = {rd_sh[14:0], adc_sdout};
    case (state)
      S_IDLE:
        if (init_start) begin
          state_n     = S_RST_PULSE;
          cnt_n       = CW'(RST_CYCLES - 1);
          init_done_n = 1'b0;
          init_mode_n = 1'b1;
          widx_n      = 2'd0;
          adc_reset_n = 1'b1;
        end else if (cmd_valid && init_done) begin
          state_n     = S_SETUP;
          cnt_n       = DIV_LD;
          sh_n        = cmd_data;
          is_rd_n     = cmd_read;
          init_mode_n = 1'b0;
          adc_sen_n   = 1'b0;
          adc_sdata_n = cmd_data[23];
        end
      S_RST_PULSE:
        if (cnt == '0) begin
          state_n     = S_RST_WAIT;
          cnt_n       = CW'(RST_WAIT - 1);
          adc_reset_n = 1'b0;
        end else cnt_n = cnt - 1'b1;
      S_RST_WAIT:
        if (cnt == '0) begin
          state_n     = S_SETUP;
          cnt_n       = DIV_LD;
          sh_n        = iw;
          is_rd_n     = 1'b0;
          adc_sen_n   = 1'b0;
          adc_sdata_n = iw[23];
        end else cnt_n = cnt - 1'b1;
      S_SETUP:
        if (cnt == '0) begin
          state_n    = S_SHIFT;
          cnt_n      = DIV_LD;
          bit_cnt_n  = 5'd23;
          ph_n       = 1'b0;
          adc_sclk_n = 1'b0;
        end else cnt_n = cnt - 1'b1;
      S_SHIFT:
        if (cnt != '0) cnt_n = cnt - 1'b1;
        else if (!ph) begin
          ph_n       = 1'b1;
          adc_sclk_n = 1'b1;
          cnt_n      = DIV_LD;
        end else if (bit_cnt == '0) begin
          state_n = S_HOLD;
          cnt_n   = DIV_LD;
          if (is_rd) begin
            rd_data_n  = rd_sh;
            rd_valid_n = 1'b1;
          end
        end else begin
          bit_cnt_n   = bit_cnt - 5'd1;
          ph_n        = 1'b0;
          adc_sclk_n  = 1'b0;
          cnt_n       = DIV_LD;
          sh_n        = {sh[22:0], 1'b0};
          adc_sdata_n = sh[22];
        end
      S_HOLD:
        if (cnt == '0) begin
          state_n     = S_GAP;
          cnt_n       = CW'(GAP_CYCLES - 1);
          adc_sen_n   = 1'b1;
          adc_sdata_n = 1'b0;
          if (init_mode && widx == LAST) init_done_n = 1'b1;
        end else cnt_n = cnt - 1'b1;
      S_GAP:
        if (cnt != '0) cnt_n = cnt - 1'b1;
        else if (init_mode && widx != LAST) begin
          state_n     = S_SETUP;
          cnt_n       = DIV_LD;
          widx_n      = widx + 2'd1;
          sh_n        = iw;
          is_rd_n     = 1'b0;
          adc_sen_n   = 1'b0;
          adc_sdata_n = iw[23];
        end else begin
          state_n     = S_IDLE;
          init_mode_n = 1'b0;
        end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_50 or posedge reset)
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      ph        <= 1'b0;
      is_rd     <= 1'b0;
      init_mode <= 1'b0;
      widx      <= 2'd0;
      sh        <= '0;
      rd_sh     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      init_done <= 1'b0;
      adc_reset <= 1'b0;
      adc_sclk  <= 1'b1;
      adc_sen   <= 1'b1;
      adc_sdata <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_cnt   <= bit_cnt_n;
      ph        <= ph_n;
      is_rd     <= is_rd_n;
      init_mode <= init_mode_n;
      widx      <= widx_n;
      sh        <= sh_n;
      rd_sh     <= rd_sh_n;
      rd_data   <= rd_data_n;
      rd_valid  <= rd_valid_n;
      init_done <= init_done_n;
      adc_reset <= adc_reset_n;
      adc_sclk  <= adc_sclk_n;
      adc_sen   <= adc_sen_n;
      adc_sdata <= adc_sdata_n;
    end
endmodule

// File: tb/tb_adc_serial_cfg_ctrl.sv
// tb_adc_serial_cfg_ctrl: pin-level frame decoder and SDOUT responder checking init, write and read sequences
module tb_adc_serial_cfg_ctrl;
  logic clk_50 = 1'b0, reset = 1'b1, init_start = 1'b0, cmd_valid = 1'b0, cmd_read = 1'b0;
  logic [23:0] cmd_data = '0;
  logic adc_sdout = 1'b0;
  logic cmd_ready, rd_valid, busy, init_done, adc_reset, adc_sclk, adc_sen, adc_sdata;
  logic [15:0] rd_data;

  adc_serial_cfg_ctrl dut (
    .clk_50(clk_50), .reset(reset), .init_start(init_start), .cmd_valid(cmd_valid),
    .cmd_read(cmd_read), .cmd_data(cmd_data), .cmd_ready(cmd_ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .init_done(init_done), .adc_reset(adc_reset),
    .adc_sclk(adc_sclk), .adc_sen(adc_sen), .adc_sdata(adc_sdata), .adc_sdout(adc_sdout)
  );

  always #10 clk_50 = ~clk_50;

  int tests = 0, fails = 0;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Pin monitor: decodes each SEN-low frame and plays an ADC that shifts out sd_val after the 8 address bits.
  typedef struct {logic [23:0] w; int nr; int sl; int fall; int gap;} frame_t;
  frame_t fr[64];
  int nf = 0, cyc = 0, nr = 0, sl = 0, fall_c = 0, gap_c = 0, rise_cyc = -1;
  int rst_hi = 0, rst_fall = 0, rst_pulses = 0, rv_cnt = 0, rv_long = 0, sclk_idle_low = 0, sdata_bad = 0;
  logic [23:0] fw = '0;
  logic [15:0] sd_val = '0;
  logic p_sen = 1'b1, p_sclk = 1'b1, p_rst = 1'b0, p_rv = 1'b0, p_sd = 1'b0;

  always @(posedge clk_50) cyc++;

  always @(negedge clk_50) begin
    if (adc_reset) rst_hi++;
    if (adc_reset && !p_rst) rst_pulses++;
    if (!adc_reset && p_rst) rst_fall = cyc;
    if (!adc_sen && p_sen) begin
      fw = '0; nr = 0; sl = 0; fall_c = cyc;
      gap_c = rise_cyc >= 0 ? cyc - rise_cyc : -1;
    end
    if (!adc_sen) begin
      sl++;
      if (adc_sclk && !p_sclk) begin
        nr++;
        fw = {fw[22:0], adc_sdata};
      end
      if (!p_sen && adc_sclk && p_sclk && adc_sdata !== p_sd) sdata_bad++;
    end
    if (adc_sen && !p_sen) begin
      if (nf < 64) fr[nf] = '{fw, nr, sl, fall_c, gap_c};
      nf++;
      rise_cyc = cyc;
    end
    if (adc_sen && !adc_sclk) sclk_idle_low++;
    if (rd_valid) begin
      rv_cnt++;
      if (p_rv) rv_long++;
    end
    adc_sdout = (!adc_sen && nr >= 9 && nr <= 24) ? sd_val[24-nr] : 1'b0;
    p_sen = adc_sen; p_sclk = adc_sclk; p_rst = adc_reset; p_rv = rd_valid; p_sd = adc_sdata;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk_50);
      n++;
    end
    check({name, " idle"}, busy, 0);
  endtask

  task automatic run_cmd(input logic rd, input logic [23:0] d, input logic [15:0] sdv,
                         input logic exp_rv, input logic [15:0] exp_rdd, input string tag);
    int f0, r0, l0, n;
    f0 = nf; r0 = rv_cnt; l0 = rv_long; n = 0;
    @(negedge clk_50);
    while (!cmd_ready && n < 100) begin
      @(negedge clk_50);
      n++;
    end
    check({tag, " ready"}, cmd_ready, 1);
    sd_val = sdv; cmd_valid = 1'b1; cmd_read = rd; cmd_data = d;
    @(negedge clk_50);
    cmd_valid = 1'b0; cmd_read = 1'($urandom); cmd_data = 24'($urandom);
    check({tag, " busy"}, busy, 1);
    wait_idle(tag, 1000);
    check({tag, " frames"}, nf - f0, 1);
    check({tag, " word"}, fr[f0].w, d);
    check({tag, " rises"}, fr[f0].nr, 24);
    check({tag, " sen_low"}, fr[f0].sl, 250);
    check({tag, " rv_pulses"}, rv_cnt - r0, exp_rv);
    check({tag, " rv_width"}, rv_long - l0, 0);
    check({tag, " rd_data"}, rd_data, exp_rdd);
  endtask

  typedef struct {logic rd; logic [23:0] d; logic [15:0] sdv; logic rv; logic [15:0] rdd;} vec_t;
  vec_t tv[8];
  logic [23:0] iw[4];

  initial begin
    int f0, h0, p0, n;
    logic rd;
    logic [23:0] d;
    logic [15:0] sdv, mrd;
    iw = '{24'h000001, 24'h000004, 24'h990008, 24'h9A000C};
    tv[0] = '{1'b0, 24'h12ABCD, 16'h0000, 1'b0, 16'h0000};
    tv[1] = '{1'b1, 24'h810000, 16'hBEEF, 1'b1, 16'hBEEF};
    tv[2] = '{1'b0, 24'h000000, 16'h1234, 1'b0, 16'hBEEF};
    tv[3] = '{1'b0, 24'hFFFFFF, 16'h0000, 1'b0, 16'hBEEF};
    tv[4] = '{1'b1, 24'h8F00FF, 16'h0001, 1'b1, 16'h0001};
    tv[5] = '{1'b1, 24'h80FFFF, 16'h8000, 1'b1, 16'h8000};
    tv[6] = '{1'b0, 24'hA5A5A5, 16'hFFFF, 1'b0, 16'h8000};
    tv[7] = '{1'b1, 24'h7E5A5A, 16'hFFFF, 1'b1, 16'hFFFF};

    // T1: reset values, held and after release; commands refused before init
    repeat (5) @(negedge clk_50);
    check("rst sclk", adc_sclk, 1);
    check("rst sen", adc_sen, 1);
    check("rst sdata", adc_sdata, 0);
    check("rst adc_reset", adc_reset, 0);
    check("rst busy", busy, 0);
    reset = 1'b0;
    cmd_valid = 1'b1; cmd_data = 24'h123456;
    repeat (20) @(negedge clk_50);
    cmd_valid = 1'b0;
    check("post init_done", init_done, 0);
    check("post cmd_ready", cmd_ready, 0);
    check("post rd_valid", rd_valid, 0);
    check("post rd_data", rd_data, 0);
    check("post busy", busy, 0);
    check("post frames", nf, 0);
    check("post sclk idle", sclk_idle_low, 0);

    // T2: power-up sequence with default timing
    f0 = nf; h0 = rst_hi;
    init_start = 1'b1;
    @(negedge clk_50);
    init_start = 1'b0;
    wait_idle("init", 3000);
    check("init rst width", rst_hi - h0, 10);
    check("init first sen", fr[f0].fall - rst_fall, 100);
    check("init frames", nf - f0, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("init w%0d", k), fr[f0+k].w, iw[k]);
      check($sformatf("init w%0d rises", k), fr[f0+k].nr, 24);
      if (k > 0) check($sformatf("init gap%0d", k), fr[f0+k].gap, 20);
    end
    check("init done", init_done, 1);
    check("init ready", cmd_ready, 1);
    check("init rv", rv_cnt, 0);

    // T3/T4 and boundary vectors
    for (int i = 0; i < 8; i++)
      run_cmd(tv[i].rd, tv[i].d, tv[i].sdv, tv[i].rv, tv[i].rdd, $sformatf("vec%0d", i));

    // Random commands against the reference: frame carries cmd_data, reads return the responder's word
    mrd = tv[7].rdd;
    for (int i = 0; i < 16; i++) begin
      rd = 1'($urandom); d = 24'($urandom); sdv = 16'($urandom);
      if (rd) mrd = sdv;
      run_cmd(rd, d, sdv, rd, mrd, $sformatf("rnd%0d", i));
    end

    // T5: init wins over a simultaneous command; a second init_start mid-frame is ignored
    @(negedge clk_50);
    f0 = nf; p0 = rst_pulses;
    init_start = 1'b1; cmd_valid = 1'b1; cmd_read = 1'b0; cmd_data = 24'h5A5A5A;
    @(negedge clk_50);
    init_start = 1'b0; cmd_valid = 1'b0;
    check("t5 init_done clr", init_done, 0);
    check("t5 busy", busy, 1);
    n = 0;
    while (!(nf > f0 && !adc_sen) && n < 2000) begin
      @(negedge clk_50);
      n++;
    end
    check("t5 in frame2", nf - f0, 1);
    repeat (60) @(negedge clk_50);
    init_start = 1'b1;
    @(negedge clk_50);
    init_start = 1'b0;
    wait_idle("t5", 3000);
    check("t5 rst pulses", rst_pulses - p0, 1);
    check("t5 frames", nf - f0, 4);
    for (int k = 0; k < 4; k++) check($sformatf("t5 w%0d", k), fr[f0+k].w, iw[k]);
    check("t5 done", init_done, 1);

    // T6: reset during bit 10 of frame 2 aborts at once
    f0 = nf;
    init_start = 1'b1;
    @(negedge clk_50);
    init_start = 1'b0;
    n = 0;
    while (!(nf == f0 + 1 && !adc_sen && nr == 13) && n < 3000) begin
      @(negedge clk_50);
      n++;
    end
    check("t6 reached bit10", nr, 13);
    reset = 1'b1;
    @(posedge clk_50);
    #1;
    check("t6 sen", adc_sen, 1);
    check("t6 sclk", adc_sclk, 1);
    check("t6 sdata", adc_sdata, 0);
    check("t6 init_done", init_done, 0);
    check("t6 busy", busy, 0);
    @(negedge clk_50);
    reset = 1'b0;
    h0 = sclk_idle_low;
    repeat (20) @(negedge clk_50);
    check("t6 stays idle", busy, 0);
    check("t6 ready", cmd_ready, 0);
    check("t6 no sclk", sclk_idle_low - h0, 0);
    check("sdata stable at sclk high", sdata_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
